// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/step sequencer for the pipelined multi-cycle core.
// Drives the core reset and clock-enable through reset sequencing, a bounded
// free-run, single-step mode and halt detection, and reports cycle count and
// stop cause.
// Optional feature: define PIPE_RUN_CTRL_BREAKPOINT_EN to stop on pc == bp_addr.
module pipe_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 21,
  parameter int RST_CYCLES = 2,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             core_rst_n,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP      = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_HALT  = 2'd2;
  localparam logic [1:0] CAUSE_BP    = 2'd3;

  // A reset phase shorter than one cycle makes no sense; clamp to one.
  localparam int RST_EFF   = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
  localparam int RST_CNT_W = (RST_EFF > 1) ? $clog2(RST_EFF) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_EFF - 1);

  localparam bit               LIMIT_EN  = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic                   step_q;
  logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   core_en_q, core_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   step_rise_s;
  logic                   bp_hit_s;
  logic                   limit_hit_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic [1:0]             stop_cause_s;

  assign step_rise_s = step & ~step_q;

`ifdef PIPE_RUN_CTRL_BREAKPOINT_EN
  assign bp_hit_s = bp_valid && (pc == bp_addr);
`else
  // Breakpoint ports stay on the interface but have no effect in this build.
  logic unused_bp_s;
  assign unused_bp_s = ^{pc, bp_addr, bp_valid};
  assign bp_hit_s    = 1'b0;
`endif

  // Saturating increment of the enabled-cycle counter; never wraps.
  always_comb begin
    cnt_inc_s = cycle_cnt_q;
    if (&cycle_cnt_q) begin
      cnt_inc_s = cycle_cnt_q;
    end else begin
      cnt_inc_s = cycle_cnt_q + 1'b1;
    end
  end

  assign limit_hit_s = LIMIT_EN && (cnt_inc_s == MAX_C);

  // Stop decision for a core-enabled cycle: halt beats breakpoint beats limit.
  always_comb begin
    stop_cause_s = CAUSE_NONE;
    if (halt_req) begin
      stop_cause_s = CAUSE_HALT;
    end else if (bp_hit_s) begin
      stop_cause_s = CAUSE_BP;
    end else if (limit_hit_s) begin
      stop_cause_s = CAUSE_LIMIT;
    end else begin
      stop_cause_s = CAUSE_NONE;
    end
  end

  // Next-state logic and next values of the run bookkeeping registers.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    cause_d     = cause_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RESET;
          mode_d      = mode;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          cause_d     = CAUSE_NONE;
        end else begin
          state_d = state_q;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = mode_q ? S_STEP_WAIT : S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        // This cycle had core_en high, so it counts.
        cycle_cnt_d = cnt_inc_s;
        if (stop_cause_s != CAUSE_NONE) begin
          state_d = S_DONE;
          cause_d = stop_cause_s;
        end else if (state_q == S_STEP) begin
          state_d = S_STEP_WAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STEP_WAIT: begin
        if (step_rise_s) begin
          state_d = S_STEP;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values decoded from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    core_rst_n_d = (state_d != S_IDLE) && (state_d != S_RESET);
    core_en_d    = (state_d == S_RUN) || (state_d == S_STEP);
    busy_d       = (state_d == S_RESET) || (state_d == S_RUN) ||
                   (state_d == S_STEP_WAIT) || (state_d == S_STEP);
    done_d       = (state_d == S_DONE);
  end

  // State, bookkeeping and registered outputs; async reset parks the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      step_q       <= 1'b0;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      cause_q      <= CAUSE_NONE;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      step_q       <= step;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      cause_q      <= cause_d;
      core_rst_n_q <= core_rst_n_d;
      core_en_q    <= core_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign core_en    = core_en_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: a vector table for single-step mode
// plus directed sequences for free-run, halt, breakpoint, async reset and
// counter saturation (second instance with MAX_CYCLES=0, CNT_W=4).
module tb_pipe_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, mode, step, halt_req, bp_valid;
  logic [31:0] pc, bp_addr;
  logic        core_rst_n, core_en, busy, done;
  logic [31:0] cycle_cnt;
  logic [1:0]  cause;

  logic        start1, mode1, step1, halt1;
  logic        core_rst_n1, core_en1, busy1, done1;
  logic [3:0]  cycle_cnt1;
  logic [1:0]  cause1;

  int errors = 0;
  int checks = 0;

  pipe_run_ctrl #(.CNT_W(32), .MAX_CYCLES(21), .RST_CYCLES(2), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .step(step),
    .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .core_rst_n(core_rst_n), .core_en(core_en), .cycle_cnt(cycle_cnt),
    .busy(busy), .done(done), .cause(cause)
  );

  pipe_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0), .RST_CYCLES(2), .PC_W(32)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .step(step1),
    .halt_req(halt1), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .core_rst_n(core_rst_n1), .core_en(core_en1), .cycle_cnt(cycle_cnt1),
    .busy(busy1), .done(done1), .cause(cause1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       mode;
    logic       step;
    logic       halt;
    logic       exp_rstn;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_cause;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a free run from IDLE/DONE and advance to the first enabled cycle.
  task automatic restart(input string tag);
    start = 1'b1;
    mode  = 1'b0;
    tick();
    chk({tag, "_rst_lo"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_cnt_clr"}, cycle_cnt, 32'd0);
    chk({tag, "_cause_clr"}, 32'(cause), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
    start = 1'b0;
    tick();
    tick();
    chk({tag, "_run_en"}, 32'(core_en), 32'd1);
  endtask

  initial begin
    int rst_lo, en_cnt, first, last;
    bit seen_done;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    pc = 32'h0; bp_addr = 32'h10; bp_valid = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; step1 = 1'b0; halt1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    chk("rst_busy_done_cause", {28'd0, busy, done, cause}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_release", {28'd0, core_en, busy, done, core_rst_n}, 32'd0);

    // Single-step table: start, mode, step, halt -> rstn, en, busy, done, cause, cnt
    vecs[0]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,2'd0,32'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,2'd0,32'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,2'd0,32'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,2'd0,32'd0};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd1};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd1};
    for (int i = 7; i <= 13; i++)
      vecs[i] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd1};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd1};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,2'd0,32'd1};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd2};
    vecs[17] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,2'd0,32'd2};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd3};
    vecs[19] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,2'd0,32'd3};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd4};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,2'd0,32'd4};

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].start; mode = vecs[i].mode;
      step = vecs[i].step;   halt_req = vecs[i].halt;
      tick();
      chk($sformatf("step_vec%0d_ctl", i),
          {28'd0, core_rst_n, core_en, busy, done},
          {28'd0, vecs[i].exp_rstn, vecs[i].exp_en, vecs[i].exp_busy, vecs[i].exp_done});
      chk($sformatf("step_vec%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
      chk($sformatf("step_vec%0d_cnt", i), cycle_cnt, vecs[i].exp_cnt);
    end
    start = 1'b0; step = 1'b0;

    // Async reset back to IDLE from STEP_WAIT
    #2 rst_n = 1'b0;
    #1 chk("async_from_step_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Free run to the cycle limit, with a start pulse while busy
    start = 1'b1; mode = 1'b0;
    tick();
    rst_lo = core_rst_n ? 0 : 1;
    start = 1'b0;
    en_cnt = 0; first = -1; last = -1; seen_done = 1'b0;
    for (int n = 0; n < 60 && !seen_done; n++) begin
      start = (core_en && cycle_cnt == 32'd10) ? 1'b1 : 1'b0;
      tick();
      if (!core_rst_n) rst_lo++;
      if (core_en) begin
        if (first < 0) begin
          first = n;
          chk("rstn_rises_with_en", 32'(core_rst_n), 32'd1);
        end
        en_cnt++;
        last = n;
      end
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    chk("free_rst_lo_cycles", 32'(rst_lo), 32'd2);
    chk("free_first_en", 32'(first), 32'd1);
    chk("free_en_cycles", 32'(en_cnt), 32'd21);
    chk("free_en_contiguous", 32'(last - first + 1), 32'd21);
    chk("free_done", 32'(seen_done), 32'd1);
    chk("free_cause", 32'(cause), 32'd1);
    chk("free_cnt", cycle_cnt, 32'd21);
    chk("free_en_at_done", 32'(core_en), 32'd0);
    repeat (3) tick();
    chk("done_hold_ctl", {28'd0, core_rst_n, core_en, busy, done}, 32'b1001);
    chk("done_hold_cnt", cycle_cnt, 32'd21);

    // Halt during the 7th enabled cycle (restart from DONE)
    restart("halt7");
    repeat (6) tick();
    chk("halt7_pre_cnt", cycle_cnt, 32'd6);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt7_done_en", {30'd0, done, core_en}, 32'b10);
    chk("halt7_cnt", cycle_cnt, 32'd7);
    chk("halt7_cause", 32'(cause), 32'd2);

    // Halt and limit in the same cycle: halt wins
    restart("halt_lim");
    repeat (20) tick();
    chk("halt_lim_pre_cnt", cycle_cnt, 32'd20);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_lim_done", 32'(done), 32'd1);
    chk("halt_lim_cnt", cycle_cnt, 32'd21);
    chk("halt_lim_cause", 32'(cause), 32'd2);

    // Breakpoint at 0x10 on the 5th enabled cycle
    restart("bp");
    bp_addr = 32'h10;
    repeat (2) tick();
    pc = 32'h10; bp_valid = 1'b0;
    tick();
    chk("bp_disarmed_no_stop", {31'd0, done}, 32'd0);
    pc = 32'h0; bp_valid = 1'b1;
    tick();
    chk("bp_pre_cnt", cycle_cnt, 32'd4);
    pc = 32'h10;
    tick();
    pc = 32'h0;
`ifdef PIPE_RUN_CTRL_BREAKPOINT_EN
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_cnt", cycle_cnt, 32'd5);
    chk("bp_cause", 32'(cause), 32'd3);
`else
    chk("bp_ignored_running", {30'd0, done, core_en}, 32'b01);
    chk("bp_ignored_cnt", cycle_cnt, 32'd5);
    for (int n = 0; n < 40 && !done; n++) tick();
    chk("bp_ignored_cnt_final", cycle_cnt, 32'd21);
    chk("bp_ignored_cause", 32'(cause), 32'd1);
`endif
    bp_valid = 1'b0;

    // Async reset mid-run at cycle_cnt=12
    restart("async");
    repeat (12) tick();
    chk("async_pre_cnt", cycle_cnt, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_core_en", 32'(core_en), 32'd0);
    chk("async_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("async_cnt", cycle_cnt, 32'd0);
    chk("async_busy_done_cause", {28'd0, busy, done, cause}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("async_idle_after", {28'd0, core_en, busy, done, core_rst_n}, 32'd0);

    // Saturation with MAX_CYCLES=0, CNT_W=4
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (2) tick();
    chk("sat_run_en", 32'(core_en1), 32'd1);
    repeat (15) tick();
    chk("sat_cnt_15", 32'(cycle_cnt1), 32'd15);
    repeat (5) tick();
    chk("sat_cnt_hold", 32'(cycle_cnt1), 32'd15);
    chk("sat_no_done", {30'd0, done1, busy1}, 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
